// File: rtl/shift_unit.sv
// shift_unit: two-stage valid/ready pipelined rotate / logical / arithmetic shifter.
// Define SHIFT_FLAGS_EN to build the CarryOut/ZeroOut result flags.
`timescale 1ns/1ps
module shift_unit #(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] IN,
  input  logic [AW-1:0]    ShiftAmt,
  input  logic             ShiftDir,
  input  logic [1:0]       Mode,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out
`ifdef SHIFT_FLAGS_EN
  ,
  output logic             CarryOut,
  output logic             ZeroOut
`endif
);
  localparam int         STAGES = 2;
  localparam logic [1:0] MROT   = 2'b00;
  localparam logic [1:0] MLSH   = 2'b01;
  localparam logic [1:0] MASH   = 2'b10;
  localparam logic [1:0] MPASS  = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    amt;
    logic             dir;
    logic [1:0]       mode;
  } opS;

  logic [STAGES:1] vldPipe;
  opS              s1Op;
  logic            adv;

  // S2 frees up when empty or being drained; S1 may refill whenever S1 moves on.
  assign adv      = !vldPipe[2] || OutReady;
  assign InReady  = !vldPipe[1] || adv;
  assign OutValid = vldPipe[2];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vldPipe <= '0;
      s1Op    <= '0;
    end else begin
      if (InReady)           vldPipe[1] <= InValid;
      if (adv)               vldPipe[2] <= vldPipe[1];
      if (InValid && InReady) s1Op      <= {IN, ShiftAmt, ShiftDir, Mode};
    end
  end

  logic [2*WIDTH-1:0] dbl, rotR, rotL;
  logic [WIDTH-1:0]   res;

  // Rotates come from a doubled operand so both ends wrap with a plain shift.
  always_comb begin
    dbl  = {s1Op.data, s1Op.data};
    rotR = dbl >> s1Op.amt;
    rotL = dbl << s1Op.amt;
    res  = s1Op.data;
    case (s1Op.mode)
      MROT:    res = s1Op.dir ? rotR[WIDTH-1:0] : rotL[2*WIDTH-1:WIDTH];
      MLSH:    res = s1Op.dir ? (s1Op.data >> s1Op.amt) : (s1Op.data << s1Op.amt);
      MASH:    res = s1Op.dir ? $unsigned($signed(s1Op.data) >>> s1Op.amt)
                              : (s1Op.data << s1Op.amt);
      default: res = s1Op.data;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                  Out <= '0;
    else if (adv && vldPipe[1])  Out <= res;
  end

`ifdef SHIFT_FLAGS_EN
  logic [AW-1:0] rIdx, lIdx;
  logic          carry, zero;

  // Rotate and shift share one carry bit: IN[k-1] going right, IN[WIDTH-k] going left.
  always_comb begin
    rIdx  = s1Op.amt - AW'(1);
    lIdx  = AW'(0) - s1Op.amt;
    carry = 1'b0;
    if (s1Op.mode != MPASS && s1Op.amt != '0)
      carry = s1Op.dir ? s1Op.data[rIdx] : s1Op.data[lIdx];
    zero  = (s1Op.mode != MPASS) && (res == '0);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      CarryOut <= 1'b0;
      ZeroOut  <= 1'b0;
    end else if (adv && vldPipe[1]) begin
      CarryOut <= carry;
      ZeroOut  <= zero;
    end
  end
`endif
endmodule
